// File: rtl/letc_core_pkg.sv
// letc_core_pkg: shared core types for the LETC pipeline.
// Holds the ALU operation and operand-source enums plus the decode->execute
// and execute->memory payload structs used by letc_core_e_stage.
package letc_core_pkg;

    localparam int XLEN = 32;

    typedef logic [XLEN-1:0] word_t;
    typedef logic [4:0]      reg_idx_t;

    // Returned by the ALU for any encoding it does not implement.
    localparam word_t ALU_UNKNOWN_RESULT = 32'hDEADBEEF;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_SLL  = 4'd2,
        ALU_SLT  = 4'd3,
        ALU_SLTU = 4'd4,
        ALU_XOR  = 4'd5,
        ALU_SRL  = 4'd6,
        ALU_SRA  = 4'd7,
        ALU_OR   = 4'd8,
        ALU_AND  = 4'd9
    } alu_op_e;

    typedef enum logic [1:0] {
        OP1_SRC_RS1  = 2'd0,
        OP1_SRC_PC   = 2'd1,
        OP1_SRC_ZERO = 2'd2
    } alu_op1_src_e;

    typedef enum logic [1:0] {
        OP2_SRC_RS2  = 2'd0,
        OP2_SRC_IMM  = 2'd1,
        OP2_SRC_FOUR = 2'd2
    } alu_op2_src_e;

    typedef struct packed {
        word_t        pc;
        word_t        rs1_val;
        word_t        rs2_val;
        reg_idx_t     rs1_idx;
        reg_idx_t     rs2_idx;
        word_t        imm;
        alu_op1_src_e op1_src;
        alu_op2_src_e op2_src;
        alu_op_e      alu_op;
        reg_idx_t     rd_idx;
        logic         rd_we;
    } d_to_e_s;

    typedef struct packed {
        word_t    result;
        word_t    rs2_val;
        reg_idx_t rd_idx;
        logic     rd_we;
        word_t    pc;
    } e_to_m_s;

    // True when the instruction held in the execute output register writes
    // the given source register (x0 is never a real producer).
    function automatic logic bypass_hit(input logic     m_valid,
                                        input logic     m_rd_we,
                                        input reg_idx_t m_rd_idx,
                                        input reg_idx_t src_idx);
        return m_valid && m_rd_we && (m_rd_idx != '0) && (m_rd_idx == src_idx);
    endfunction

endpackage

// File: rtl/letc_core_e_stage_if.sv
// letc_core_e_stage_if: decode->execute and execute->memory handshake bundle.
// Handshake rule on both sides: a transfer happens on a rising clock edge
// where valid and ready are both high; the producer holds its payload stable
// while valid is high and ready is low, and ready never depends on valid.
// The slave modport is the execute stage's view, master is the surroundings.
interface letc_core_e_stage_if;
    import letc_core_pkg::*;

    logic         i_flush;
    logic         i_d_valid;
    logic         o_d_ready;
    word_t        i_d_pc;
    word_t        i_d_rs1_val;
    word_t        i_d_rs2_val;
    reg_idx_t     i_d_rs1_idx;
    reg_idx_t     i_d_rs2_idx;
    word_t        i_d_imm;
    alu_op1_src_e i_d_op1_src;
    alu_op2_src_e i_d_op2_src;
    alu_op_e      i_d_alu_op;
    reg_idx_t     i_d_rd_idx;
    logic         i_d_rd_we;

    logic         o_m_valid;
    logic         i_m_ready;
    word_t        o_m_result;
    word_t        o_m_rs2_val;
    reg_idx_t     o_m_rd_idx;
    logic         o_m_rd_we;
    word_t        o_m_pc;

    modport slave (
        input  i_flush, i_d_valid, i_d_pc, i_d_rs1_val, i_d_rs2_val,
               i_d_rs1_idx, i_d_rs2_idx, i_d_imm, i_d_op1_src, i_d_op2_src,
               i_d_alu_op, i_d_rd_idx, i_d_rd_we, i_m_ready,
        output o_d_ready, o_m_valid, o_m_result, o_m_rs2_val, o_m_rd_idx,
               o_m_rd_we, o_m_pc
    );

    modport master (
        output i_flush, i_d_valid, i_d_pc, i_d_rs1_val, i_d_rs2_val,
               i_d_rs1_idx, i_d_rs2_idx, i_d_imm, i_d_op1_src, i_d_op2_src,
               i_d_alu_op, i_d_rd_idx, i_d_rd_we, i_m_ready,
        input  o_d_ready, o_m_valid, o_m_result, o_m_rs2_val, o_m_rd_idx,
               o_m_rd_we, o_m_pc
    );

endinterface

// File: rtl/letc_core_alu.sv
// letc_core_alu: single-cycle combinational integer ALU.
// Results wrap modulo 2^32, shifts use b[4:0], unknown ops give DEADBEEF.
module letc_core_alu
    import letc_core_pkg::*;
(
    input  alu_op_e i_op,
    input  word_t   i_a,
    input  word_t   i_b,
    output word_t   o_result
);

    logic [4:0] shamt;
    assign shamt = i_b[4:0];

    // Evaluate the requested operation on the two operands
    always_comb begin
        o_result = ALU_UNKNOWN_RESULT;
        case (i_op)
            ALU_ADD:  o_result = i_a + i_b;
            ALU_SUB:  o_result = i_a - i_b;
            ALU_SLL:  o_result = i_a << shamt;
            ALU_SLT:  o_result = {31'd0, $signed(i_a) < $signed(i_b)};
            ALU_SLTU: o_result = {31'd0, i_a < i_b};
            ALU_XOR:  o_result = i_a ^ i_b;
            ALU_SRL:  o_result = i_a >> shamt;
            ALU_SRA:  o_result = word_t'($signed(i_a) >>> shamt);
            ALU_OR:   o_result = i_a | i_b;
            ALU_AND:  o_result = i_a & i_b;
            default:  o_result = ALU_UNKNOWN_RESULT;
        endcase
    end

endmodule

// File: rtl/letc_core_e_bypass.sv
// letc_core_e_bypass: forwards the execute stage's own registered result
// into the next instruction's rs1/rs2 values when it is the producer.
module letc_core_e_bypass
    import letc_core_pkg::*;
(
    input  logic     i_m_valid,
    input  logic     i_m_rd_we,
    input  reg_idx_t i_m_rd_idx,
    input  word_t    i_m_result,
    input  reg_idx_t i_rs1_idx,
    input  reg_idx_t i_rs2_idx,
    input  word_t    i_rs1_val,
    input  word_t    i_rs2_val,
    output word_t    o_rs1_val,
    output word_t    o_rs2_val
);

    logic rs1_hit;
    logic rs2_hit;

    // Compare held destination against each source and mux the result in
    always_comb begin
        rs1_hit   = bypass_hit(i_m_valid, i_m_rd_we, i_m_rd_idx, i_rs1_idx);
        rs2_hit   = bypass_hit(i_m_valid, i_m_rd_we, i_m_rd_idx, i_rs2_idx);
        o_rs1_val = rs1_hit ? i_m_result : i_rs1_val;
        o_rs2_val = rs2_hit ? i_m_result : i_rs2_val;
    end

endmodule

// File: rtl/letc_core_e_stage.sv
// letc_core_e_stage: LETC execute stage. Selects ALU operands, computes the
// result and registers it with writeback metadata in a one-entry output
// register for the memory stage. Flush kills both the held and the incoming
// instruction. Optional feature macro: LETC_CORE_E_BYPASS_EN forwards the
// held result into the next instruction's register operands.
module letc_core_e_stage
    import letc_core_pkg::*;
(
    input  logic                      i_clk,
    input  logic                      i_rst_n,
    letc_core_e_stage_if.slave        bus
);

    d_to_e_s d;
    word_t   rs1_val;
    word_t   rs2_val;
    word_t   op1;
    word_t   op2;
    word_t   alu_result;
    logic    d_ready;
    logic    accept;

    logic    m_valid_q;
    logic    m_valid_d;
    e_to_m_s payload_q;
    e_to_m_s payload_d;

    // Gather the decode-side inputs into one payload view
    always_comb begin
        d.pc      = bus.i_d_pc;
        d.rs1_val = bus.i_d_rs1_val;
        d.rs2_val = bus.i_d_rs2_val;
        d.rs1_idx = bus.i_d_rs1_idx;
        d.rs2_idx = bus.i_d_rs2_idx;
        d.imm     = bus.i_d_imm;
        d.op1_src = bus.i_d_op1_src;
        d.op2_src = bus.i_d_op2_src;
        d.alu_op  = bus.i_d_alu_op;
        d.rd_idx  = bus.i_d_rd_idx;
        d.rd_we   = bus.i_d_rd_we;
    end

`ifdef LETC_CORE_E_BYPASS_EN
    letc_core_e_bypass u_bypass (
        .i_m_valid  (m_valid_q),
        .i_m_rd_we  (payload_q.rd_we),
        .i_m_rd_idx (payload_q.rd_idx),
        .i_m_result (payload_q.result),
        .i_rs1_idx  (d.rs1_idx),
        .i_rs2_idx  (d.rs2_idx),
        .i_rs1_val  (d.rs1_val),
        .i_rs2_val  (d.rs2_val),
        .o_rs1_val  (rs1_val),
        .o_rs2_val  (rs2_val)
    );
`else
    // Without forwarding the hazard unit stalls decode, so indices are unused.
    logic unused_src_idx;
    assign unused_src_idx = ^{d.rs1_idx, d.rs2_idx};
    assign rs1_val = d.rs1_val;
    assign rs2_val = d.rs2_val;
`endif

    // Pick ALU operands from register values, PC, immediate or constants
    always_comb begin
        op1 = '0;
        op2 = '0;
        case (d.op1_src)
            OP1_SRC_RS1:  op1 = rs1_val;
            OP1_SRC_PC:   op1 = d.pc;
            OP1_SRC_ZERO: op1 = '0;
            default:      op1 = '0;
        endcase
        case (d.op2_src)
            OP2_SRC_RS2:  op2 = rs2_val;
            OP2_SRC_IMM:  op2 = d.imm;
            OP2_SRC_FOUR: op2 = 32'd4;
            default:      op2 = '0;
        endcase
    end

    letc_core_alu u_alu (
        .i_op     (d.alu_op),
        .i_a      (op1),
        .i_b      (op2),
        .o_result (alu_result)
    );

    assign d_ready = !m_valid_q || bus.i_m_ready;
    assign accept  = bus.i_d_valid && d_ready && !bus.i_flush;

    // Next-state for the output register: flush beats accept beats consume
    always_comb begin
        m_valid_d = m_valid_q;
        payload_d = payload_q;
        if (bus.i_flush) begin
            m_valid_d = 1'b0;
        end else if (accept) begin
            m_valid_d         = 1'b1;
            payload_d.result  = alu_result;
            payload_d.rs2_val = rs2_val;
            payload_d.rd_idx  = d.rd_idx;
            payload_d.rd_we   = d.rd_we && (d.rd_idx != '0);
            payload_d.pc      = d.pc;
        end else if (m_valid_q && bus.i_m_ready) begin
            m_valid_d = 1'b0;
        end
    end

    // Output register with asynchronous clear
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            m_valid_q <= 1'b0;
            payload_q <= '0;
        end else begin
            m_valid_q <= m_valid_d;
            payload_q <= payload_d;
        end
    end

    assign bus.o_d_ready   = d_ready;
    assign bus.o_m_valid   = m_valid_q;
    assign bus.o_m_result  = payload_q.result;
    assign bus.o_m_rs2_val = payload_q.rs2_val;
    assign bus.o_m_rd_idx  = payload_q.rd_idx;
    assign bus.o_m_rd_we   = payload_q.rd_we;
    assign bus.o_m_pc      = payload_q.pc;

endmodule

// File: tb/tb_letc_core_e_stage.sv
// tb_letc_core_e_stage: scoreboard bench for letc_core_e_stage. The driver
// issues directed and random instructions and pushes the expected output
// record; a negedge monitor compares whatever the stage presents.
module tb_letc_core_e_stage;
    import letc_core_pkg::*;

    localparam int W = $bits(e_to_m_s);

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    letc_core_e_stage_if bus();

    letc_core_e_stage dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus)
    );

    logic [W-1:0] exp_q[$];
    int           checks = 0;
    int           errors = 0;
    logic         mon_en = 1'b0;

    // Reference state: is an instruction held this cycle, and what it is
    logic         mdl_valid     = 1'b0;
    logic         mdl_valid_nxt = 1'b0;
    logic         exp_ready     = 1'b1;
    e_to_m_s      mdl_held      = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Architectural meaning of each ALU encoding, written from the rules
    function automatic word_t ref_alu(input logic [3:0] op, input word_t a, input word_t b);
        int    sh;
        int    sa;
        int    sb;
        word_t ones;
        sh   = int'(b & 32'd31);
        sa   = a;
        sb   = b;
        ones = 32'hFFFF_FFFF;
        case (op)
            4'd0: return a + b;
            4'd1: return a - b;
            4'd2: return a << sh;
            4'd3: return (sa < sb) ? 32'd1 : 32'd0;
            4'd4: return (a < b) ? 32'd1 : 32'd0;
            4'd5: return a ^ b;
            4'd6: return a >> sh;
            4'd7: return (a >> sh) | (a[31] ? ~(ones >> sh) : 32'd0);
            4'd8: return a | b;
            4'd9: return a & b;
            default: return 32'hDEAD_BEEF;
        endcase
    endfunction

    // Drive one cycle of inputs and predict the stage's reaction
    task automatic step(input logic v, input word_t pc, input word_t r1v, input word_t r2v,
                        input reg_idx_t r1i, input reg_idx_t r2i, input word_t imm,
                        input logic [1:0] s1, input logic [1:0] s2, input logic [3:0] op,
                        input reg_idx_t rd, input logic we, input logic mr, input logic fl);
        word_t   a1;
        word_t   a2;
        word_t   x;
        word_t   y;
        e_to_m_s e;
        @(posedge clk);
        #1;
        mdl_valid = mdl_valid_nxt;
        bus.i_d_valid   = v;
        bus.i_d_pc      = pc;
        bus.i_d_rs1_val = r1v;
        bus.i_d_rs2_val = r2v;
        bus.i_d_rs1_idx = r1i;
        bus.i_d_rs2_idx = r2i;
        bus.i_d_imm     = imm;
        bus.i_d_op1_src = alu_op1_src_e'(s1);
        bus.i_d_op2_src = alu_op2_src_e'(s2);
        bus.i_d_alu_op  = alu_op_e'(op);
        bus.i_d_rd_idx  = rd;
        bus.i_d_rd_we   = we;
        bus.i_m_ready   = mr;
        bus.i_flush     = fl;
        exp_ready = !mdl_valid || mr;
        if (fl) begin
            if (mdl_valid) void'(exp_q.pop_back());
            mdl_valid_nxt = 1'b0;
        end else if (v && exp_ready) begin
            a1 = r1v;
            a2 = r2v;
`ifdef LETC_CORE_E_BYPASS_EN
            // The newest producer still sitting in the stage owns the value
            if (mdl_valid && mdl_held.rd_we && r1i == mdl_held.rd_idx) a1 = mdl_held.result;
            if (mdl_valid && mdl_held.rd_we && r2i == mdl_held.rd_idx) a2 = mdl_held.result;
`endif
            x = (s1 == 2'd0) ? a1 : (s1 == 2'd1) ? pc : 32'd0;
            y = (s2 == 2'd0) ? a2 : (s2 == 2'd1) ? imm : 32'd4;
            e.result  = ref_alu(op, x, y);
            e.rs2_val = a2;
            e.rd_idx  = rd;
            e.rd_we   = we && (rd != 5'd0);
            e.pc      = pc;
            exp_q.push_back(W'(e));
            mdl_held      = e;
            mdl_valid_nxt = 1'b1;
        end else if (mdl_valid && mr) begin
            mdl_valid_nxt = 1'b0;
        end
    endtask

    task automatic idle(input logic mr);
        step(1'b0, 32'd0, 32'd0, 32'd0, 5'd0, 5'd0, 32'd0, 2'd0, 2'd0, 4'd0, 5'd0, 1'b0, mr, 1'b0);
    endtask

    // Spend one idle cycle, then check the result shown during it
    task automatic hold_check(input logic mr, input string name, input word_t exp);
        idle(mr);
        @(negedge clk);
        check(name, bus.o_m_result, exp);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_valid"},   {31'd0, bus.o_m_valid}, 32'd0);
        check({tag, "_result"},  bus.o_m_result, 32'd0);
        check({tag, "_rs2_val"}, bus.o_m_rs2_val, 32'd0);
        check({tag, "_rd_idx"},  {27'd0, bus.o_m_rd_idx}, 32'd0);
        check({tag, "_rd_we"},   {31'd0, bus.o_m_rd_we}, 32'd0);
        check({tag, "_pc"},      bus.o_m_pc, 32'd0);
        check({tag, "_ready"},   {31'd0, bus.o_d_ready}, 32'd1);
    endtask

    task automatic random_phase(input int n);
        for (int i = 0; i < n; i++) begin
            step($urandom_range(0, 3) != 0, $urandom, $urandom, $urandom,
                 reg_idx_t'($urandom_range(0, 3)), reg_idx_t'($urandom_range(0, 3)), $urandom,
                 2'($urandom_range(0, 2)), 2'($urandom_range(0, 2)), 4'($urandom_range(0, 15)),
                 reg_idx_t'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                 $urandom_range(0, 9) < 7, $urandom_range(0, 15) == 0);
        end
    endtask

    // Monitor: compare presented output against the oldest expected record
    always @(negedge clk) begin
        e_to_m_s e;
        if (mon_en && rst_n) begin
            check("d_ready", {31'd0, bus.o_d_ready}, {31'd0, exp_ready});
            check("m_valid", {31'd0, bus.o_m_valid}, {31'd0, mdl_valid});
            if (bus.o_m_valid && !bus.i_flush) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_output", 32'd1, 32'd0);
                end else begin
                    e = e_to_m_s'(exp_q[0]);
                    check("result",  bus.o_m_result, e.result);
                    check("rs2_val", bus.o_m_rs2_val, e.rs2_val);
                    check("rd_idx",  {27'd0, bus.o_m_rd_idx}, {27'd0, e.rd_idx});
                    check("rd_we",   {31'd0, bus.o_m_rd_we}, {31'd0, e.rd_we});
                    check("pc",      bus.o_m_pc, e.pc);
                    if (bus.i_m_ready) void'(exp_q.pop_front());
                end
            end
        end
    end

    initial begin
        bus.i_flush     = 1'b0;
        bus.i_d_valid   = 1'b0;
        bus.i_d_pc      = '0;
        bus.i_d_rs1_val = '0;
        bus.i_d_rs2_val = '0;
        bus.i_d_rs1_idx = '0;
        bus.i_d_rs2_idx = '0;
        bus.i_d_imm     = '0;
        bus.i_d_op1_src = OP1_SRC_RS1;
        bus.i_d_op2_src = OP2_SRC_RS2;
        bus.i_d_alu_op  = ALU_ADD;
        bus.i_d_rd_idx  = '0;
        bus.i_d_rd_we   = 1'b0;
        bus.i_m_ready   = 1'b1;

        #12;
        check_reset_outputs("reset");
        #10;
        rst_n  = 1'b1;
        mon_en = 1'b1;

        // ADD 5+7 into x5, then stall three cycles with the result held
        step(1'b1, 32'h0, 32'd5, 32'd7, 5'd3, 5'd4, 32'd0, 2'd0, 2'd0, 4'd0, 5'd5, 1'b1, 1'b1, 1'b0);
        hold_check(1'b0, "add_5_7", 32'd12);
        check("add_rd_idx", {27'd0, bus.o_m_rd_idx}, 32'd5);
        hold_check(1'b0, "stall_hold_1", 32'd12);
        hold_check(1'b0, "stall_hold_2", 32'd12);
        check("stall_ready", {31'd0, bus.o_d_ready}, 32'd0);
        // Release plus SUB 3-5 in the same cycle
        step(1'b1, 32'h4, 32'd3, 32'd5, 5'd6, 5'd7, 32'd0, 2'd0, 2'd0, 4'd1, 5'd6, 1'b1, 1'b1, 1'b0);
        hold_check(1'b1, "sub_3_5", 32'hFFFF_FFFE);

        // PC + 4 and zero + immediate
        step(1'b1, 32'h100, 32'd9, 32'd9, 5'd1, 5'd2, 32'd0, 2'd1, 2'd2, 4'd0, 5'd1, 1'b1, 1'b1, 1'b0);
        hold_check(1'b1, "pc_plus_four", 32'h104);
        step(1'b1, 32'h108, 32'd9, 32'd9, 5'd1, 5'd2, 32'hFFFF_F800, 2'd2, 2'd1, 4'd0, 5'd1, 1'b1, 1'b1, 1'b0);
        hold_check(1'b1, "zero_plus_imm", 32'hFFFF_F800);

        // Flush with a held result and a new instruction offered
        step(1'b1, 32'h200, 32'd1, 32'd2, 5'd1, 5'd2, 32'd0, 2'd0, 2'd0, 4'd0, 5'd7, 1'b1, 1'b0, 1'b0);
        step(1'b1, 32'h204, 32'd3, 32'd4, 5'd1, 5'd2, 32'd0, 2'd0, 2'd0, 4'd0, 5'd8, 1'b1, 1'b1, 1'b1);
        idle(1'b1);
        @(negedge clk);
        check("flush_kills", {31'd0, bus.o_m_valid}, 32'd0);

        // ADDI x1 = 10, then ADD x2 = x1 + x1 with stale register data
        step(1'b1, 32'h300, 32'd0, 32'd0, 5'd0, 5'd0, 32'd10, 2'd0, 2'd1, 4'd0, 5'd1, 1'b1, 1'b1, 1'b0);
        step(1'b1, 32'h304, 32'd0, 32'd0, 5'd1, 5'd1, 32'd0, 2'd0, 2'd0, 4'd0, 5'd2, 1'b1, 1'b1, 1'b0);
`ifdef LETC_CORE_E_BYPASS_EN
        hold_check(1'b1, "bypass_x1", 32'd20);
`else
        hold_check(1'b1, "no_bypass_x1", 32'd0);
`endif
        // A write to x0 must never be forwarded
        step(1'b1, 32'h308, 32'd0, 32'd0, 5'd0, 5'd0, 32'd10, 2'd0, 2'd1, 4'd0, 5'd0, 1'b1, 1'b1, 1'b0);
        step(1'b1, 32'h30C, 32'd0, 32'd0, 5'd0, 5'd0, 32'd0, 2'd0, 2'd0, 4'd0, 5'd3, 1'b1, 1'b1, 1'b0);
        hold_check(1'b1, "x0_not_bypassed", 32'd0);

        // Asynchronous reset in the middle of a stall
        step(1'b1, 32'h400, 32'd7, 32'd8, 5'd1, 5'd2, 32'd0, 2'd0, 2'd0, 4'd5, 5'd4, 1'b1, 1'b0, 1'b0);
        idle(1'b0);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("async_reset");
        exp_q.delete();
        mdl_valid     = 1'b0;
        mdl_valid_nxt = 1'b0;
        exp_ready     = 1'b1;
        @(posedge clk);
        #2;
        rst_n = 1'b1;

        random_phase(500);

        for (int i = 0; i < 4; i++) idle(1'b1);
        @(negedge clk);
        check("queue_drained", exp_q.size(), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
